// File: rtl/icache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the N-way instruction-cache controller.
// PLRU vectors are carried at the 8-way width; callers pad/trim to their own WAYS.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  localparam int MAX_WAYS   = 8;
  localparam int MAX_PLRU_W = MAX_WAYS - 1;
  localparam int MIN_SETS   = 2;

  function automatic bit ways_legal(input int ways);
    return (ways == 2) || (ways == 4) || (ways == 8);
  endfunction

  function automatic bit sets_legal(input int sets);
    return (sets >= MIN_SETS) && ((sets & (sets - 1)) == 0);
  endfunction

  function automatic int plru_levels(input int ways);
    return (ways >= 8) ? 3 : ((ways >= 4) ? 2 : 1);
  endfunction

  // Walk from the root; a node bit of 0 sends the victim into the lower-way half.
  function automatic logic [2:0] plru_victim(input logic [MAX_PLRU_W-1:0] plru, input int ways);
    logic [3:0] node;
    node = 4'd0;
    for (int l = 0; l < 3; l++) begin
      if (l < plru_levels(ways)) begin
        node = {node[2:0], 1'b0} + 4'd1 + {3'b000, plru[node[2:0]]};
      end
    end
    return 3'(node - 4'(ways - 1));
  endfunction

  // Every node on the path to the hit way is pointed at the opposite half.
  function automatic logic [MAX_PLRU_W-1:0] plru_update(input logic [MAX_PLRU_W-1:0] plru,
                                                         input logic [2:0] way, input int ways);
    logic [MAX_PLRU_W-1:0] upd;
    logic [3:0]            node;
    logic [1:0]            bsel;
    logic                  dir;
    upd  = plru;
    node = 4'd0;
    for (int l = 0; l < 3; l++) begin
      if (l < plru_levels(ways)) begin
        bsel            = 2'(plru_levels(ways) - 1 - l);
        dir             = way[bsel];
        upd[node[2:0]]  = ~dir;
        node            = {node[2:0], 1'b0} + 4'd1 + {3'b000, dir};
      end
    end
    return upd;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Combinational tree-PLRU victim selection and hit-driven update for one indexed set.
module icache_plru
  import icache_pkg::*;
#(
  parameter  int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_out,
  input  logic [WAYS-1:0]  hit_way,
  output logic [WAY_W-1:0] victim_idx,
  output logic [WAYS-2:0]  plru_next
);

  logic [MAX_PLRU_W-1:0] w_plru_pad;
  logic [WAY_W-1:0]      w_hit_idx;

  assign w_plru_pad = MAX_PLRU_W'(plru_out);

  // A multi-hot match resolves to the lowest way.
  always_comb begin
    w_hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_way[i]) w_hit_idx = WAY_W'(i);
    end
  end

  assign victim_idx = WAY_W'(plru_victim(w_plru_pad, WAYS));
  assign plru_next  = (WAYS-1)'(plru_update(w_plru_pad, 3'(w_hit_idx), WAYS));

endmodule

// File: rtl/icache_control_nway.sv
// N-way instruction-cache controller: lookup, line fill, and whole-cache flush walk.
// Define ICACHE_PERF_EN to add the hit_count/miss_count performance counters.
module icache_control_nway
  import icache_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  valid_out,
  input  logic [WAYS-2:0]  plru_out,
  output logic [WAYS-2:0]  plru_in,
  output logic             load_plru,
  output logic [WAYS-1:0]  load_valid,
  output logic [WAYS-1:0]  set_valid,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  data_load,
  output logic             mem_enable_sel,
  output logic             pmem_read,
  input  logic             pmem_resp,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_sel,
  output logic [IDX_W-1:0] flush_index
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  state_e           r_state, w_state_next;
  logic             r_flush_pending;
  logic [IDX_W-1:0] r_flush_index;
  logic [WAY_W-1:0] r_victim, w_victim_next;
  logic [WAY_W-1:0] w_plru_victim, w_invalid_idx;
  logic [WAYS-2:0]  w_plru_next;
  logic [WAYS-1:0]  w_fill_mask;
  logic             w_any_invalid, w_hit, w_flush_last;

  icache_plru #(.WAYS(WAYS)) u_plru (
    .plru_out   (plru_out),
    .hit_way    (hit_way),
    .victim_idx (w_plru_victim),
    .plru_next  (w_plru_next)
  );

  // Empty ways are filled before any valid line is evicted.
  always_comb begin
    w_invalid_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_out[i]) w_invalid_idx = WAY_W'(i);
    end
  end

  assign w_any_invalid = ~&valid_out;
  assign w_hit         = |hit_way;
  assign w_fill_mask   = WAYS'(1) << r_victim;
  assign w_flush_last  = (r_flush_index == IDX_W'(SETS - 1));
  assign flush_busy    = r_flush_pending;
  assign flush_index   = r_flush_index;

  always_comb begin
    w_state_next   = r_state;
    w_victim_next  = r_victim;
    mem_resp       = 1'b0;
    load_plru      = 1'b0;
    plru_in        = '0;
    load_valid     = '0;
    set_valid      = '0;
    load_tag       = '0;
    data_load      = '0;
    mem_enable_sel = 1'b0;
    pmem_read      = 1'b0;
    flush_sel      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_flush_pending || flush_req) w_state_next = ST_FLUSH;
        else if (mem_read)                w_state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!mem_read) begin
          w_state_next = ST_IDLE;
        end else if (w_hit) begin
          mem_resp     = 1'b1;
          load_plru    = 1'b1;
          plru_in      = w_plru_next;
          w_state_next = ST_IDLE;
        end else begin
          w_victim_next = w_any_invalid ? w_invalid_idx : w_plru_victim;
          w_state_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_read      = 1'b1;
        mem_enable_sel = 1'b1;
        if (pmem_resp) begin
          data_load    = w_fill_mask;
          load_tag     = w_fill_mask;
          load_valid   = w_fill_mask;
          set_valid    = w_fill_mask;
          w_state_next = ST_LOOKUP;
        end
      end
      ST_FLUSH: begin
        flush_sel  = 1'b1;
        load_valid = '1;
        load_plru  = 1'b1;
        if (w_flush_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_flush_pending <= 1'b0;
      r_flush_index   <= '0;
      r_victim        <= '0;
    end else begin
      r_state         <= w_state_next;
      r_victim        <= w_victim_next;
      r_flush_pending <= flush_req | (r_flush_pending & ~((r_state == ST_FLUSH) & w_flush_last));
      r_flush_index   <= (r_state == ST_FLUSH) ? r_flush_index + IDX_W'(1) : '0;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count, r_miss_count;
  logic        w_miss;

  assign w_miss = (r_state == ST_LOOKUP) & mem_read & ~w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (mem_resp) r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss)   r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_control_nway.sv
// Self-checking bench for icache_control_nway (WAYS=4, SETS=8) with a response/fill scoreboard.
module tb_icache_control_nway;

  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic       clk, rst_n, mem_read, mem_resp, load_plru, mem_enable_sel, pmem_read, pmem_resp;
  logic       flush_req, flush_busy, flush_sel;
  logic [3:0] hit_way, valid_out, load_valid, set_valid, load_tag, data_load;
  logic [2:0] plru_out, plru_in, flush_index;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [2:0] exp_plru_q[$];
  logic [3:0] exp_fill_q[$];

  icache_control_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_resp(mem_resp),
    .hit_way(hit_way), .valid_out(valid_out), .plru_out(plru_out), .plru_in(plru_in),
    .load_plru(load_plru), .load_valid(load_valid), .set_valid(set_valid),
    .load_tag(load_tag), .data_load(data_load), .mem_enable_sel(mem_enable_sel),
    .pmem_read(pmem_read), .pmem_resp(pmem_resp), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_sel(flush_sel), .flush_index(flush_index)
`ifdef ICACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each response / fill is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_resp === 1'b1) begin
        n_cmp++;
        if (exp_plru_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_resp: mem_resp=1 plru_in=%b, required no response", plru_in);
        end else begin
          logic [2:0] e;
          e = exp_plru_q.pop_front();
          if (plru_in !== e || load_plru !== 1'b1) begin
            n_err++;
            $display("FAIL sb_resp: plru_in=%b load_plru=%b, required plru_in=%b load_plru=1",
                     plru_in, load_plru, e);
          end else $display("resp ok: plru_in=%b", plru_in);
        end
      end
      if (load_tag !== 4'b0000) begin
        n_cmp++;
        if (exp_fill_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_fill: load_tag=%b, required no fill", load_tag);
        end else begin
          logic [3:0] m;
          m = exp_fill_q.pop_front();
          if (load_tag !== m || data_load !== m || load_valid !== m || set_valid !== m) begin
            n_err++;
            $display("FAIL sb_fill: tag=%b data=%b lv=%b sv=%b, required all %b",
                     load_tag, data_load, load_valid, set_valid, m);
          end else $display("fill ok: way mask %b", m);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 1'b0; hit_way = '0; valid_out = '0; plru_out = '0;
    pmem_resp = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_resp, load_plru, plru_in, load_valid, set_valid, load_tag, data_load,
         mem_enable_sel, pmem_read, flush_busy, flush_sel, flush_index} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: resp=%b pmem=%b busy=%b sel=%b idx=%0d lv=%b, required all 0",
               mem_resp, pmem_read, flush_busy, flush_sel, flush_index, load_valid);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || flush_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: resp=%b pmem=%b busy=%b, required 0 0 0", mem_resp, pmem_read, flush_busy);
    end
    step();
  endtask

  task automatic test_hit();
    logic [3:0] hw[4] = '{4'b0010, 4'b0001, 4'b1100, 4'b1000};
    logic [2:0] po[4] = '{3'b000, 3'b000, 3'b011, 3'b111};
    logic [2:0] ex[4] = '{3'b001, 3'b011, 3'b110, 3'b010};
    for (int k = 0; k < 4; k++) begin
      mem_read = 1'b1; hit_way = hw[k]; plru_out = po[k]; valid_out = 4'hF;
      exp_plru_q.push_back(ex[k]); exp_hits++;
      @(negedge clk);
      n_cmp++;
      if (mem_resp !== 1'b0) begin
        n_err++; $display("FAIL hit_early: mem_resp=%b in IDLE, required 0", mem_resp);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (mem_resp !== 1'b1) begin
        n_err++; $display("FAIL hit_latency: case %0d mem_resp=%b, required 1", k, mem_resp);
      end
      step();
      mem_read = 1'b0; hit_way = '0;
      @(negedge clk);
      n_cmp++;
      if (mem_resp !== 1'b0) begin
        n_err++; $display("FAIL hit_single: mem_resp=%b after response, required 0", mem_resp);
      end
      step();
    end
  endtask

  task automatic test_miss();
    logic [3:0] vv[6] = '{4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
    logic [2:0] po[6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b101, 3'b000};
    logic [3:0] mk[6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b1000};
    logic [2:0] ex[6] = '{3'b011, 3'b001, 3'b011, 3'b100, 3'b000, 3'b000};
    for (int k = 0; k < 6; k++) begin
      mem_read = 1'b1; hit_way = '0; valid_out = vv[k]; plru_out = po[k];
      exp_misses++;
      step();
      @(negedge clk);
      n_cmp++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
        n_err++; $display("FAIL miss_lookup: resp=%b pmem=%b, required 0 0", mem_resp, pmem_read);
      end
      step();
      exp_fill_q.push_back(mk[k]);
      for (int w = 0; w <= k; w++) begin
        @(negedge clk);
        n_cmp++;
        if (pmem_read !== 1'b1 || mem_enable_sel !== 1'b1 || load_tag !== 4'b0000) begin
          n_err++;
          $display("FAIL fill_wait: pmem=%b sel=%b tag=%b, required 1 1 0000", pmem_read, mem_enable_sel, load_tag);
        end
        step();
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (load_tag !== mk[k]) begin
        n_err++; $display("FAIL fill_victim: case %0d load_tag=%b, required %b", k, load_tag, mk[k]);
      end
      step();
      pmem_resp = 1'b0; hit_way = mk[k]; valid_out = vv[k] | mk[k];
      exp_plru_q.push_back(ex[k]); exp_hits++;
      @(negedge clk);
      n_cmp++;
      if (mem_resp !== 1'b1) begin
        n_err++; $display("FAIL refill_resp: mem_resp=%b after pmem_resp, required 1", mem_resp);
      end
      step();
      mem_read = 1'b0; hit_way = '0;
    end
  endtask

  task automatic test_fill_drop();
    mem_read = 1'b1; hit_way = '0; valid_out = 4'hF; plru_out = 3'b010;
    exp_misses++;
    step();
    step();
    exp_fill_q.push_back(4'b0010);
    mem_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pmem_read !== 1'b1) begin
      n_err++; $display("FAIL fill_hold: pmem_read=%b after mem_read drop, required 1", pmem_read);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (load_tag !== 4'b0010) begin
      n_err++; $display("FAIL fill_drop_victim: load_tag=%b, required 0010", load_tag);
    end
    step();
    pmem_resp = 1'b0; hit_way = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b0) begin
      n_err++; $display("FAIL drop_no_resp: mem_resp=%b with mem_read low, required 0", mem_resp);
    end
    step();
    hit_way = '0;
    @(negedge clk);
    n_cmp++;
    if (pmem_read !== 1'b0) begin
      n_err++; $display("FAIL drop_idle: pmem_read=%b, required 0", pmem_read);
    end
    step();
  endtask

  task automatic test_flush_during_fill();
    mem_read = 1'b1; hit_way = '0; valid_out = 4'hF; plru_out = 3'b000;
    exp_misses++;
    step();
    step();
    exp_fill_q.push_back(4'b0001);
    flush_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (flush_busy !== 1'b0) begin
      n_err++; $display("FAIL busy_early: flush_busy=%b in request cycle, required 0", flush_busy);
    end
    step();
    flush_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (flush_busy !== 1'b1 || pmem_read !== 1'b1 || flush_sel !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_fill: busy=%b pmem=%b sel=%b, required 1 1 0", flush_busy, pmem_read, flush_sel);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (load_tag !== 4'b0001) begin
      n_err++; $display("FAIL flush_fill_intact: load_tag=%b, required 0001", load_tag);
    end
    step();
    pmem_resp = 1'b0; hit_way = 4'b0001;
    exp_plru_q.push_back(3'b011); exp_hits++;
    @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b1) begin
      n_err++; $display("FAIL flush_relookup: mem_resp=%b, required 1", mem_resp);
    end
    step();
    mem_read = 1'b0; hit_way = '0;
    @(negedge clk);
    n_cmp++;
    if (flush_busy !== 1'b1 || flush_sel !== 1'b0) begin
      n_err++; $display("FAIL flush_pending_idle: busy=%b sel=%b, required 1 0", flush_busy, flush_sel);
    end
    step();
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      n_cmp++;
      if (flush_sel !== 1'b1 || flush_index !== 3'(i) || load_valid !== 4'hF || set_valid !== 4'h0 ||
          load_plru !== 1'b1 || plru_in !== 3'b000 || flush_busy !== 1'b1 || pmem_read !== 1'b0) begin
        n_err++;
        $display("FAIL flush_cycle: i=%0d sel=%b idx=%0d lv=%b sv=%b lp=%b pi=%b busy=%b, required 1 %0d 1111 0000 1 000 1",
                 i, flush_sel, flush_index, load_valid, set_valid, load_plru, plru_in, flush_busy, i);
      end else $display("flush ok: index %0d", flush_index);
      step();
    end
    @(negedge clk);
    n_cmp++;
    if (flush_busy !== 1'b0 || flush_sel !== 1'b0) begin
      n_err++; $display("FAIL flush_done: busy=%b sel=%b, required 0 0", flush_busy, flush_sel);
    end
    step();
  endtask

  task automatic test_flush_read_same();
    mem_read = 1'b1; flush_req = 1'b1; hit_way = 4'b0010; valid_out = 4'hF; plru_out = 3'b000;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      n_cmp++;
      if (flush_sel !== 1'b1 || mem_resp !== 1'b0 || flush_index !== 3'(i)) begin
        n_err++;
        $display("FAIL flush_first: i=%0d sel=%b resp=%b idx=%0d, required 1 0 %0d", i, flush_sel, mem_resp, flush_index, i);
      end
      step();
    end
    exp_plru_q.push_back(3'b001); exp_hits++;
    @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b0 || flush_busy !== 1'b0) begin
      n_err++; $display("FAIL read_waits: resp=%b busy=%b, required 0 0", mem_resp, flush_busy);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b1) begin
      n_err++; $display("FAIL read_after_flush: mem_resp=%b, required 1", mem_resp);
    end
    step();
    mem_read = 1'b0; hit_way = '0;
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1; hit_way = '0; valid_out = 4'hF; plru_out = 3'b000;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (pmem_read !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_fill: pmem_read=%b, required 1", pmem_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pmem_read !== 1'b0) begin
      n_err++; $display("FAIL async_pmem_drop: pmem_read=%b under reset, required 0", pmem_read);
    end
    exp_hits = 0; exp_misses = 0;
    mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pmem_read !== 1'b0 || mem_resp !== 1'b0 || flush_busy !== 1'b0) begin
        n_err++; $display("FAIL idle_after_reset: pmem=%b resp=%b busy=%b, required 0 0 0", pmem_read, mem_resp, flush_busy);
      end
      step();
    end
  endtask

  task automatic test_perf();
`ifdef ICACHE_PERF_EN
    n_cmp++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_err++; $display("FAIL perf_reset: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      mem_read = 1'b1; hit_way = 4'b0001; valid_out = 4'hF; plru_out = 3'b000;
      exp_plru_q.push_back(3'b011); exp_hits++;
      step();
      step();
      mem_read = 1'b0; hit_way = '0;
    end
    for (int k = 0; k < 2; k++) begin
      mem_read = 1'b1; hit_way = '0;
      exp_misses++;
      step();
      step();
      exp_fill_q.push_back(4'b0001);
      mem_read = 1'b0; pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      step();
    end
    step();
`ifdef ICACHE_PERF_EN
    n_cmp++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_err++; $display("FAIL perf_counts: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end else $display("perf ok: hit=%0d miss=%0d", hit_count, miss_count);
`endif
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_fill_drop();
    test_flush_during_fill();
    test_flush_read_same();
    test_reset_mid_fill();
    test_perf();
    n_cmp++;
    if (exp_plru_q.size() != 0 || exp_fill_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses and %0d fills outstanding, required 0 0",
               exp_plru_q.size(), exp_fill_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
